caravel_wb_bridge: RTL and testbench

Terminates the Caravel management-core Wishbone slave port inside `soc` and converts each classic Wishbone cycle into a single valid/ready request plus a response on the internal SoC register bus. It decodes the user address window and aborts stalled transactions with a timeout. It also reports bus errors to `caravel_interrupt_o` logic. The block sits directly behind the `caravel_wbs_*` ports of `soc`, upstream of the internal peripheral interconnect.

---
 rtl/soc_bus_pkg.sv | 31 +++
 rtl/caravel_wb_bridge.sv | 211 +++++++++++++++++++++
 tb/tb_caravel_wb_bridge.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/soc_bus_pkg.sv
// soc_bus_pkg: shared types for the SoC register bus.
// FSM encoding, error read-data codes, request/response bundles.
package soc_bus_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_RSP   = 3'd2,
    ST_ACK   = 3'd3,
    ST_DRAIN = 3'd4
  } bus_state_e;

  localparam logic [31:0] BAD0_ADD0 = 32'hBAD0_ADD0;
  localparam logic [31:0] BAD0_0E55 = 32'hBAD0_0E55;
  localparam logic [31:0] DEAD_DEAD = 32'hDEAD_DEAD;

  localparam int unsigned CNT_W = 8;

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
  } soc_req_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } soc_rsp_t;

endpackage

// File: rtl/caravel_wb_bridge.sv
// caravel_wb_bridge: Wishbone classic slave -> valid/ready register bus.
// Ports: caravel_wbs_* (WB slave), req_*/rsp_* (SoC bus), err_irq_o/err_count_o.
module caravel_wb_bridge
  import soc_bus_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR      = 32'h3000_0000,
  parameter logic [31:0] ADDR_MASK      = 32'hFFF0_0000,
  parameter int unsigned OFFS_W         = 20,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              caravel_wbs_stb_i,
  input  logic              caravel_wbs_cyc_i,
  input  logic              caravel_wbs_we_i,
  input  logic [3:0]        caravel_wbs_sel_i,
  input  logic [31:0]       caravel_wbs_dat_i,
  input  logic [31:0]       caravel_wbs_adr_i,
  output logic              caravel_wbs_ack_o,
  output logic [31:0]       caravel_wbs_dat_o,
  output logic              req_valid_o,
  input  logic              req_ready_i,
  output logic              req_we_o,
  output logic [OFFS_W-1:0] req_addr_o,
  output logic [31:0]       req_wdata_o,
  output logic [3:0]        req_strb_o,
  input  logic              rsp_valid_i,
  input  logic [31:0]       rsp_rdata_i,
  input  logic              rsp_err_i,
  output logic              err_irq_o,
  output logic [7:0]        err_count_o
);

  localparam logic [CNT_W-1:0] TMO_LAST =
    CNT_W'(TIMEOUT_CYCLES - 1);

  bus_state_e        state_q;
  logic [CNT_W-1:0]  tmo_cnt_q;
  logic [7:0]        err_cnt_q;
  logic              ack_q;
  logic              irq_q;
  logic              valid_q;
  logic              we_q;
  logic [31:0]       dat_q;
  logic [31:0]       wdata_q;
  logic [OFFS_W-1:0] addr_q;
  logic [3:0]        strb_q;

  logic              wb_go;
  logic              hit;
  logic              tmo;
  logic              cyc;
  soc_rsp_t          rsp;

  logic              fin_d;
  logic              ferr_d;
  logic [31:0]       fdat_d;

  assign cyc   = caravel_wbs_cyc_i;
  assign wb_go = caravel_wbs_stb_i & cyc;
  assign hit   = (caravel_wbs_adr_i & ADDR_MASK)
              == (BASE_ADDR & ADDR_MASK);
  assign tmo   = tmo_cnt_q == TMO_LAST;
  assign rsp   = '{rdata: rsp_rdata_i,
                   err:   rsp_err_i};

  // Which transitions end in an ack, and with what data.
  // A response in the last budget cycle beats the timeout.
  always_comb begin
    fin_d  = 1'b0;
    ferr_d = 1'b0;
    fdat_d = '0;
    unique case (state_q)
      ST_IDLE: begin
        if (wb_go && !hit) begin
          fin_d  = 1'b1;
          ferr_d = 1'b1;
          fdat_d = BAD0_ADD0;
        end
      end
      ST_REQ: begin
        if (cyc && tmo) begin
          fin_d  = 1'b1;
          ferr_d = 1'b1;
          fdat_d = DEAD_DEAD;
        end
      end
      ST_RSP: begin
        if (cyc && rsp_valid_i) begin
          fin_d  = 1'b1;
          ferr_d = rsp.err;
          if (rsp.err) begin
            fdat_d = BAD0_0E55;
          end else if (!we_q) begin
            fdat_d = rsp.rdata;
          end
        end else if (cyc && tmo) begin
          fin_d  = 1'b1;
          ferr_d = 1'b1;
          fdat_d = DEAD_DEAD;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      tmo_cnt_q <= '0;
      err_cnt_q <= '0;
      ack_q     <= 1'b0;
      irq_q     <= 1'b0;
      valid_q   <= 1'b0;
      we_q      <= 1'b0;
      dat_q     <= '0;
      wdata_q   <= '0;
      addr_q    <= '0;
      strb_q    <= '0;
    end else begin
      ack_q <= 1'b0;
      irq_q <= 1'b0;

      if (state_q == ST_IDLE && wb_go) begin
        we_q    <= caravel_wbs_we_i;
        strb_q  <= caravel_wbs_sel_i;
        wdata_q <= caravel_wbs_dat_i;
        addr_q  <= caravel_wbs_adr_i[OFFS_W-1:0];
      end

      if (fin_d) begin
        state_q <= ST_ACK;
        ack_q   <= 1'b1;
        dat_q   <= fdat_d;
        valid_q <= 1'b0;
        irq_q   <= ferr_d;
        if (ferr_d && err_cnt_q != 8'hFF) begin
          err_cnt_q <= err_cnt_q + 8'd1;
        end
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            tmo_cnt_q <= '0;
            dat_q     <= '0;
            if (wb_go) begin
              state_q <= ST_REQ;
              valid_q <= 1'b1;
            end
          end
          ST_REQ: begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
            if (!cyc) begin
              if (tmo) begin
                state_q <= ST_IDLE;
                valid_q <= 1'b0;
              end else begin
                // An unaccepted request stays up in DRAIN.
                state_q <= ST_DRAIN;
                if (req_ready_i) begin
                  valid_q <= 1'b0;
                end
              end
            end else if (req_ready_i) begin
              state_q <= ST_RSP;
              valid_q <= 1'b0;
            end
          end
          ST_RSP: begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
            if (!cyc) begin
              state_q <= (rsp_valid_i || tmo)
                       ? ST_IDLE : ST_DRAIN;
            end
          end
          ST_ACK: begin
            state_q <= ST_IDLE;
            dat_q   <= '0;
          end
          ST_DRAIN: begin
            tmo_cnt_q <= tmo_cnt_q + 1'b1;
            if (tmo) begin
              state_q <= ST_IDLE;
              valid_q <= 1'b0;
            end else if (valid_q) begin
              if (req_ready_i) begin
                valid_q <= 1'b0;
              end
            end else if (rsp_valid_i) begin
              state_q <= ST_IDLE;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            valid_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign caravel_wbs_ack_o = ack_q;
  assign caravel_wbs_dat_o = dat_q;
  assign req_valid_o       = valid_q;
  assign req_we_o          = we_q;
  assign req_addr_o        = addr_q;
  assign req_wdata_o       = wdata_q;
  assign req_strb_o        = strb_q;
  assign err_irq_o         = irq_q;
  assign err_count_o       = err_cnt_q;

endmodule

// File: tb/tb_caravel_wb_bridge.sv
// tb_caravel_wb_bridge: transaction-level model vs bridge outputs.
// Directed cases pin the model; random cases exercise timing mixes.
module tb_caravel_wb_bridge;

  localparam int T = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stb, cyc, we;
  logic [3:0]  sel;
  logic [31:0] wdat, adr;
  logic        ack;
  logic [31:0] dato;
  logic        rv, rr, rwe;
  logic [19:0] raddr;
  logic [31:0] rwd;
  logic [3:0]  rstrb;
  logic        sv, serr;
  logic [31:0] srd;
  logic        irq;
  logic [7:0]  ecnt;

  always #5 clk = ~clk;

  caravel_wb_bridge #(
    .TIMEOUT_CYCLES(T)
  ) dut (
    .clk_i(clk),
    .rst_ni(rst_n),
    .caravel_wbs_stb_i(stb),
    .caravel_wbs_cyc_i(cyc),
    .caravel_wbs_we_i(we),
    .caravel_wbs_sel_i(sel),
    .caravel_wbs_dat_i(wdat),
    .caravel_wbs_adr_i(adr),
    .caravel_wbs_ack_o(ack),
    .caravel_wbs_dat_o(dato),
    .req_valid_o(rv),
    .req_ready_i(rr),
    .req_we_o(rwe),
    .req_addr_o(raddr),
    .req_wdata_o(rwd),
    .req_strb_o(rstrb),
    .rsp_valid_i(sv),
    .rsp_rdata_i(srd),
    .rsp_err_i(serr),
    .err_irq_o(irq),
    .err_count_o(ecnt)
  );

  int n_chk  = 0;
  int n_pass = 0;

  logic        chk_en = 1'b0;
  logic        exp_ack = 1'b0;
  logic        exp_valid = 1'b0;
  logic        exp_irq = 1'b0;
  logic [31:0] exp_dat = '0;
  logic        exp_we = 1'b0;
  logic [19:0] exp_addr = '0;
  logic [31:0] exp_wd = '0;
  logic [3:0]  exp_strb = '0;
  int          cnt_model = 0;

  int          o_nack, o_ackk, o_nvalid;
  logic [31:0] o_dat, o_wd;
  logic [19:0] o_addr;
  logic        o_we, o_irq;
  logic [3:0]  o_strb;
  logic [7:0]  o_cnt;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] req);
    n_chk++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %h want %h", nm, act, req);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ack", 32'(ack), 32'(exp_ack));
      chk("req_valid", 32'(rv), 32'(exp_valid));
      chk("err_irq", 32'(irq), 32'(exp_irq));
      chk("err_count", 32'(ecnt), 32'(cnt_model));
      if (exp_ack) chk("ack_dat", dato, exp_dat);
      if (exp_valid) begin
        chk("req_we", 32'(rwe), 32'(exp_we));
        chk("req_addr", 32'(raddr), 32'(exp_addr));
        chk("req_wdata", rwd, exp_wd);
        chk("req_strb", 32'(rstrb), 32'(exp_strb));
      end
    end
  end

  // One Wishbone cycle. dr: cycles of valid before ready,
  // ds: cycles in RSP before the response, ab: cycle cyc drops.
  task automatic xact(input logic [31:0] a,
                      input logic w,
                      input logic [3:0] s,
                      input logic [31:0] d,
                      input int dr,
                      input int ds,
                      input logic [31:0] rd,
                      input logic re,
                      input int ab);
    logic hit, hs, err, live;
    logic [31:0] dat;
    int ks, kend, last, vlast;
    hit = ((a & 32'hFFF0_0000) == 32'h3000_0000);
    hs  = hit && (dr + 1 <= T - 1);
    ks  = dr + 2 + ds;
    if (!hit) begin
      kend = 0; err = 1'b1; dat = 32'hBAD0_ADD0;
    end else if (hs && ks <= T) begin
      kend = ks; err = re;
      dat = re ? 32'hBAD0_0E55 : (w ? 32'h0 : rd);
    end else begin
      kend = T; err = 1'b1; dat = 32'hDEAD_DEAD;
    end
    vlast = !hit ? 0 : (hs ? dr + 1 : T);
    last  = (ab > 0) ? ks + 1 : kend + 2;
    if (ab == 0 && hs && ks > last) last = ks;
    o_nack = 0; o_ackk = -1; o_nvalid = 0;
    o_dat = '0; o_wd = '0; o_addr = '0;
    o_we = 1'b0; o_irq = 1'b0; o_strb = '0; o_cnt = '0;
    for (int k = 0; k <= last; k++) begin
      live = (ab > 0) ? (k < ab) : (k <= kend + 1);
      stb  = live;
      cyc  = live;
      adr  = a; we = w; sel = s; wdat = d;
      rr   = hit && (k == dr + 1);
      sv   = hs && (k == ks);
      srd  = sv ? rd : $urandom;
      serr = sv ? re : 1'($urandom);
      exp_valid = hit && k >= 1 && k <= vlast;
      exp_ack   = (ab == 0) && (k == kend + 1);
      exp_irq   = exp_ack && err;
      exp_dat   = dat;
      exp_we    = w;
      exp_addr  = a[19:0];
      exp_wd    = d;
      exp_strb  = s;
      if (exp_irq && cnt_model < 255) cnt_model++;
      if (ack) begin
        o_nack++;
        if (o_nack == 1) begin
          o_ackk = k; o_dat = dato; o_irq = irq; o_cnt = ecnt;
        end
      end
      if (rv) begin
        o_nvalid++;
        o_addr = raddr; o_we = rwe; o_wd = rwd; o_strb = rstrb;
      end
      @(posedge clk); #1;
    end
    stb = 1'b0; cyc = 1'b0; rr = 1'b0; sv = 1'b0;
    exp_ack = 1'b0; exp_valid = 1'b0; exp_irq = 1'b0;
  endtask

  initial begin
    logic [31:0] ra;
    rst_n = 1'b0;
    stb = 1'b0; cyc = 1'b0; we = 1'b0; sel = '0;
    wdat = '0; adr = '0; rr = 1'b0; sv = 1'b0;
    srd = '0; serr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ack", 32'(ack), 32'h0);
    chk("rst_dat", dato, 32'h0);
    chk("rst_valid", 32'(rv), 32'h0);
    chk("rst_addr", 32'(raddr), 32'h0);
    chk("rst_cnt", 32'(ecnt), 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_en = 1'b1;

    xact(32'h3000_0010, 1'b0, 4'hF, 32'h0, 0, 0,
         32'h1234_5678, 1'b0, 0);
    chk("rd_ack_cycle", o_ackk, 32'd3);
    chk("rd_dat", o_dat, 32'h1234_5678);
    chk("rd_addr", 32'(o_addr), 32'h10);
    chk("rd_cnt", 32'(ecnt), 32'h0);

    xact(32'h3000_0004, 1'b1, 4'b0101, 32'hCAFE_F00D, 1, 1,
         32'h5555_AAAA, 1'b0, 0);
    chk("wr_we", 32'(o_we), 32'h1);
    chk("wr_strb", 32'(o_strb), 32'h5);
    chk("wr_wdata", o_wd, 32'hCAFE_F00D);
    chk("wr_nack", o_nack, 32'd1);
    chk("wr_dat", o_dat, 32'h0);

    xact(32'h2000_0000, 1'b0, 4'hF, 32'h0, 0, 0,
         32'h0, 1'b0, 0);
    chk("oow_ack_cycle", o_ackk, 32'd1);
    chk("oow_dat", o_dat, 32'hBAD0_ADD0);
    chk("oow_nvalid", o_nvalid, 32'd0);
    chk("oow_irq", 32'(o_irq), 32'h1);
    chk("oow_cnt", 32'(o_cnt), 32'h1);

    xact(32'h3000_0100, 1'b0, 4'hF, 32'h0, 0, 7,
         32'h1111_2222, 1'b0, 0);
    chk("tmo_ack_cycle", o_ackk, 32'd9);
    chk("tmo_dat", o_dat, 32'hDEAD_DEAD);
    chk("tmo_nack", o_nack, 32'd1);
    chk("tmo_cnt", 32'(o_cnt), 32'h2);

    xact(32'h3000_0200, 1'b0, 4'hF, 32'h0, 0, 6,
         32'h7777_8888, 1'b0, 0);
    chk("edge_ack_cycle", o_ackk, 32'd9);
    chk("edge_dat", o_dat, 32'h7777_8888);

    xact(32'h3000_0300, 1'b0, 4'hF, 32'h0, 0, 2,
         32'h0000_0009, 1'b0, 2);
    chk("abort_nack", o_nack, 32'd0);
    xact(32'h3000_0304, 1'b0, 4'hF, 32'h0, 0, 0,
         32'hA5A5_5A5A, 1'b0, 0);
    chk("post_abort_cycle", o_ackk, 32'd3);
    chk("post_abort_dat", o_dat, 32'hA5A5_5A5A);

    for (int i = 0; i < 60; i++) begin
      ra = ($urandom_range(0, 3) != 0)
         ? {12'h300, 20'($urandom)} : $urandom;
      xact(ra, 1'($urandom), 4'($urandom), $urandom,
           $urandom_range(0, 9), $urandom_range(0, 9),
           $urandom, ($urandom_range(0, 3) == 0), 0);
    end

    for (int i = 0; i < 300; i++) begin
      xact(32'h4000_0000 + 32'(i), 1'b0, 4'hF, 32'h0, 0, 0,
           32'h0, 1'b0, 0);
    end
    chk("sat_cnt", 32'(ecnt), 32'd255);

    chk_en = 1'b0;
    stb = 1'b1; cyc = 1'b1; adr = 32'h3000_0400;
    we = 1'b0; rr = 1'b0; sv = 1'b0;
    @(posedge clk); #1;
    chk("rst_pre_valid", 32'(rv), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 32'(rv), 32'h0);
    chk("rst_mid_ack", 32'(ack), 32'h0);
    chk("rst_mid_cnt", 32'(ecnt), 32'h0);
    stb = 1'b0; cyc = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    cnt_model = 0;
    @(posedge clk); #1;
    chk_en = 1'b1;
    xact(32'h3000_0008, 1'b0, 4'hF, 32'h0, 0, 1,
         32'h0BAD_CAFE, 1'b0, 0);
    chk("post_rst_cycle", o_ackk, 32'd4);
    chk("post_rst_dat", o_dat, 32'h0BAD_CAFE);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
